// File: rtl/alu_operand_stage.sv
// Operand-B select stage for the ALU: picks register, immediate (zero/sign-extended) or
// forwarded data, and buffers it in a 2-entry skid buffer with valid/ready handshakes.
module alu_operand_stage #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned IMM_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] read_data2,
    input  logic [IMM_WIDTH-1:0]  immediate,
    input  logic [1:0]            alu_src,
    input  logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_src
);

    if (IMM_WIDTH < 1 || IMM_WIDTH > DATA_WIDTH) begin : g_bad_imm_width
        $error("alu_operand_stage: IMM_WIDTH must lie in 1..DATA_WIDTH");
    end

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StHalf  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [1:0]            r_main_src;
    logic [1:0]            r_skid_src;
    logic [DATA_WIDTH-1:0] w_main_next;
    logic [DATA_WIDTH-1:0] w_skid_next;
    logic [1:0]            w_main_src_next;
    logic [1:0]            w_skid_src_next;
    logic [DATA_WIDTH-1:0] w_sel;
    logic                  w_accept;
    logic                  w_emit;

    // Handshake outputs come from state flops only, so no in_valid/out_ready comb path.
    assign out_valid = (r_state != StEmpty);
    assign in_ready  = (r_state != StFull);
    assign out_data  = r_main;
    assign out_src   = r_main_src;

    assign w_accept = in_valid & in_ready;
    assign w_emit   = out_valid & out_ready;

    always_comb begin
        w_sel = read_data2;
        unique case (alu_src)
            2'b00:   w_sel = read_data2;
            2'b01:   w_sel = DATA_WIDTH'(immediate);
            2'b10:   w_sel = DATA_WIDTH'($signed(immediate));
            default: w_sel = fwd_data;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_main_next     = r_main;
        w_skid_next     = r_skid;
        w_main_src_next = r_main_src;
        w_skid_src_next = r_skid_src;
        if (flush) begin
            w_state_next    = StEmpty;
            w_main_next     = '0;
            w_skid_next     = '0;
            w_main_src_next = '0;
            w_skid_src_next = '0;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        w_state_next    = StHalf;
                        w_main_next     = w_sel;
                        w_main_src_next = alu_src;
                    end
                end
                StHalf: begin
                    if (w_accept && w_emit) begin
                        w_main_next     = w_sel;
                        w_main_src_next = alu_src;
                    end else if (w_accept) begin
                        w_state_next    = StFull;
                        w_skid_next     = w_sel;
                        w_skid_src_next = alu_src;
                    end else if (w_emit) begin
                        w_state_next = StEmpty;
                    end
                end
                StFull: begin
                    if (w_emit) begin
                        w_state_next    = StHalf;
                        w_main_next     = r_skid;
                        w_main_src_next = r_skid_src;
                    end
                end
                default: w_state_next = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StEmpty;
            r_main     <= '0;
            r_skid     <= '0;
            r_main_src <= '0;
            r_skid_src <= '0;
        end else begin
            r_state    <= w_state_next;
            r_main     <= w_main_next;
            r_skid     <= w_skid_next;
            r_main_src <= w_main_src_next;
            r_skid_src <= w_skid_src_next;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed steps on a 4/3-bit instance, then a random soak
// of an 8/5-bit instance against a queue-based reference model.
module tb_alu_operand_stage;

    logic clock;
    logic reset_n;

    // Instance A: DATA_WIDTH=4, IMM_WIDTH=3
    logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0] a_rd, a_fwd, a_out_data;
    logic [2:0] a_imm;
    logic [1:0] a_src, a_out_src;

    // Instance B: DATA_WIDTH=8, IMM_WIDTH=5
    logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_rd, b_fwd, b_out_data;
    logic [4:0] b_imm;
    logic [1:0] b_src, b_out_src;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
    } entry_t;
    entry_t q[$];

    alu_operand_stage #(.DATA_WIDTH(4), .IMM_WIDTH(3)) u_dut_a (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (a_flush),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .read_data2 (a_rd),
        .immediate  (a_imm),
        .alu_src    (a_src),
        .fwd_data   (a_fwd),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data),
        .out_src    (a_out_src)
    );

    alu_operand_stage #(.DATA_WIDTH(8), .IMM_WIDTH(5)) u_dut_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (b_flush),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .read_data2 (b_rd),
        .immediate  (b_imm),
        .alu_src    (b_src),
        .fwd_data   (b_fwd),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .out_src    (b_out_src)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] s, input logic [3:0] rd,
                           input logic [2:0] imm, input logic [3:0] fwd);
        a_in_valid = v;
        a_src      = s;
        a_rd       = rd;
        a_imm      = imm;
        a_fwd      = fwd;
    endtask

    // Reference selection for the 8/5 instance, from the arithmetic definition.
    function automatic logic [7:0] ref_sel(input logic [1:0] s, input logic [7:0] rd,
                                           input logic [4:0] imm, input logic [7:0] fwd);
        int unsigned v;
        case (s)
            2'd0:    v = int'(rd);
            2'd1:    v = int'(imm);
            2'd2:    v = (imm >= 5'd16) ? int'(imm) + 256 - 32 : int'(imm);
            default: v = int'(fwd);
        endcase
        return 8'(v);
    endfunction

    initial begin
        logic [3:0] vals [4];
        logic [1:0] srcs [4];
        logic       acc, emi;
        entry_t     e;

        reset_n = 1'b0;
        a_flush = 0; a_out_ready = 0; drive_a(0, 2'd0, 4'd0, 3'd0, 4'd0);
        b_flush = 0; b_out_ready = 0; b_in_valid = 0;
        b_src = 0; b_rd = 0; b_imm = 0; b_fwd = 0;
        #1;
        chk("por_out_valid", 32'(a_out_valid), 0);
        chk("por_in_ready", 32'(a_in_ready), 1);
        chk("por_out_data", 32'(a_out_data), 0);
        #3 reset_n = 1'b1;
        tick();

        // 1. Fill to FULL with 3 at the head, then reset between edges
        drive_a(1, 2'd0, 4'd3, 3'd0, 4'd0);
        tick();
        drive_a(1, 2'd0, 4'd1, 3'd0, 4'd0);
        tick();
        a_in_valid = 0;
        chk("full_out_data", 32'(a_out_data), 3);
        chk("full_in_ready", 32'(a_in_ready), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_in_ready", 32'(a_in_ready), 1);
        chk("rst_out_data", 32'(a_out_data), 0);
        chk("rst_out_src", 32'(a_out_src), 0);
        #2 reset_n = 1'b1;
        drive_a(1, 2'd0, 4'd5, 3'd0, 4'd0);
        tick();
        chk("post_rst_valid", 32'(a_out_valid), 1);
        chk("post_rst_data", 32'(a_out_data), 5);
        a_in_valid = 0; a_out_ready = 1;
        tick();
        chk("post_rst_drain", 32'(a_out_valid), 0);

        // 2. Pass-through at full rate
        vals[0] = 4'd2; vals[1] = 4'd5; vals[2] = 4'd3; vals[3] = 4'd6;
        srcs[0] = 2'd0; srcs[1] = 2'd1; srcs[2] = 2'd0; srcs[3] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            drive_a(1, srcs[i], ~vals[i], vals[i][2:0], 4'd15);
            if (srcs[i] == 2'd0) a_rd = vals[i];
            tick();
            chk("pass_valid", 32'(a_out_valid), 1);
            chk("pass_data", 32'(a_out_data), 32'(vals[i]));
            chk("pass_src", 32'(a_out_src), 32'(srcs[i]));
        end
        a_in_valid = 0;
        tick();
        chk("pass_drain", 32'(a_out_valid), 0);

        // 3. Extension and forwarding
        drive_a(1, 2'd1, 4'd0, 3'b101, 4'd0); tick();
        chk("zext_101", 32'(a_out_data), 5);
        drive_a(1, 2'd2, 4'd0, 3'b101, 4'd0); tick();
        chk("sext_101", 32'(a_out_data), 13);
        drive_a(1, 2'd2, 4'd0, 3'b011, 4'd0); tick();
        chk("sext_011", 32'(a_out_data), 3);
        drive_a(1, 2'd3, 4'd0, 3'b101, 4'd9); tick();
        chk("fwd_9", 32'(a_out_data), 9);
        chk("fwd_src", 32'(a_out_src), 3);
        a_in_valid = 0;
        tick();

        // 4. Backpressure
        a_out_ready = 0;
        drive_a(1, 2'd0, 4'd3, 3'd0, 4'd0); tick();
        chk("bp_first", 32'(a_out_data), 3);
        chk("bp_ready1", 32'(a_in_ready), 1);
        a_rd = 4'd6; tick();
        chk("bp_ready0", 32'(a_in_ready), 0);
        chk("bp_hold1", 32'(a_out_data), 3);
        a_rd = 4'd7; tick();
        chk("bp_hold2", 32'(a_out_data), 3);
        tick();
        chk("bp_hold3", 32'(a_out_data), 3);
        chk("bp_still_full", 32'(a_in_ready), 0);
        a_out_ready = 1; tick();
        chk("bp_out6", 32'(a_out_data), 6);
        tick();
        chk("bp_out7", 32'(a_out_data), 7);
        a_in_valid = 0; tick();
        chk("bp_no_dup", 32'(a_out_valid), 0);

        // 5. Flush while FULL with a competing request
        a_out_ready = 0;
        drive_a(1, 2'd0, 4'd1, 3'd0, 4'd0); tick();
        a_rd = 4'd2; tick();
        a_rd = 4'd4; a_flush = 1; tick();
        a_flush = 0;
        chk("flush_valid", 32'(a_out_valid), 0);
        chk("flush_ready", 32'(a_in_ready), 1);
        chk("flush_data", 32'(a_out_data), 0);
        a_rd = 4'd0; a_out_ready = 1; tick();
        chk("flush_next_valid", 32'(a_out_valid), 1);
        chk("flush_next_data", 32'(a_out_data), 0);
        a_in_valid = 0; tick();
        chk("flush_no_4", 32'(a_out_valid), 0);

        // 6. Random soak on the 8/5 instance
        q.delete();
        for (int c = 0; c < 1000; c++) begin
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_flush     = ($urandom_range(0, 49) == 0);
            b_rd  = 8'($urandom);
            b_imm = 5'($urandom);
            b_src = 2'($urandom);
            b_fwd = 8'($urandom);
            acc = b_in_valid && (q.size() < 2);
            emi = b_out_ready && (q.size() > 0);
            e.d = ref_sel(b_src, b_rd, b_imm, b_fwd);
            e.s = b_src;
            tick();
            if (b_flush) begin
                q.delete();
            end else begin
                if (emi) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            chk("soak_valid", 32'(b_out_valid), 32'(q.size() > 0));
            chk("soak_ready", 32'(b_in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("soak_data", 32'(b_out_data), 32'(q[0].d));
                chk("soak_src", 32'(b_out_src), 32'(q[0].s));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
